// File: rtl/memory_arbiter.sv
// Two-port (fetch / load-store) arbiter and access sequencer for a start-pulse memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module memory_arbiter #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 inst_req,
   input  logic [WORD_SIZE-1:0] inst_address,
   output logic                 inst_ack,
   output logic [WORD_SIZE-1:0] inst_rdata,
   output logic                 inst_err,
   input  logic                 data_req,
   input  logic                 data_write,
   input  logic [WORD_SIZE-1:0] data_address,
   input  logic [WORD_SIZE-1:0] data_wdata,
   output logic                 data_ack,
   output logic [WORD_SIZE-1:0] data_rdata,
   output logic                 data_err,
   output logic                 mem_start,
   output logic                 mem_write_enabled,
   output logic                 mem_read_enabled,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_input_data,
   input  logic                 mem_valid,
   input  logic [WORD_SIZE-1:0] mem_output_data,
   input  logic                 mem_err_invalid_address,
   output logic                 busy
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;
   typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

   state_t               state;
   grant_t               grant;
   logic [CW-1:0]        wait_count;
   logic                 pick_data;
   logic                 resp_now;
   logic                 resp_err;
   logic [WORD_SIZE-1:0] resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   grant_t last_grant;
   always_comb pick_data = data_req && (!inst_req || last_grant == GRANT_INST);
`else
   always_comb pick_data = data_req;
`endif

   // Decide whether this cycle closes the access: address error in SETUP, or write/valid/timeout in WAIT.
   always_comb begin
      resp_now  = 1'b0;
      resp_err  = 1'b0;
      resp_data = '0;
      case (state)
         SETUP: begin
            if (mem_err_invalid_address) begin
               resp_now = 1'b1;
               resp_err = 1'b1;
            end
         end
         WAIT: begin
            if (mem_write_enabled) begin
               resp_now = 1'b1;
            end else if (mem_valid) begin
               resp_now  = 1'b1;
               resp_data = mem_output_data;
            end else if (wait_count == TIMEOUT_LAST) begin
               resp_now = 1'b1;
               resp_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state             <= IDLE;
         grant             <= GRANT_INST;
         wait_count        <= '0;
         inst_ack          <= 1'b0;
         inst_rdata        <= '0;
         inst_err          <= 1'b0;
         data_ack          <= 1'b0;
         data_rdata        <= '0;
         data_err          <= 1'b0;
         mem_start         <= 1'b0;
         mem_write_enabled <= 1'b0;
         mem_read_enabled  <= 1'b0;
         mem_address       <= '0;
         mem_input_data    <= '0;
         busy              <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant        <= GRANT_INST;
`endif
      end else begin
         inst_ack  <= 1'b0;
         data_ack  <= 1'b0;
         mem_start <= 1'b0;
         if (resp_now) begin
            state             <= RESP;
            mem_write_enabled <= 1'b0;
            mem_read_enabled  <= 1'b0;
            if (grant == GRANT_DATA) begin
               data_ack   <= 1'b1;
               data_err   <= resp_err;
               data_rdata <= resp_data;
            end else begin
               inst_ack   <= 1'b1;
               inst_err   <= resp_err;
               inst_rdata <= resp_data;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (inst_req || data_req) begin
                     state             <= SETUP;
                     busy              <= 1'b1;
                     grant             <= pick_data ? GRANT_DATA : GRANT_INST;
                     mem_address       <= pick_data ? data_address : inst_address;
                     mem_input_data    <= pick_data ? data_wdata : '0;
                     mem_write_enabled <= pick_data && data_write;
                     mem_read_enabled  <= !(pick_data && data_write);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                     last_grant        <= pick_data ? GRANT_DATA : GRANT_INST;
`endif
                  end
               end
               SETUP: begin
                  state     <= START;
                  mem_start <= 1'b1;
               end
               START: begin
                  state      <= WAIT;
                  wait_count <= '0;
               end
               WAIT: wait_count <= wait_count + 1'b1;
               RESP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter with a stub memory and a transaction-level reference model.
module tb_memory_arbiter;

   localparam int W        = 32;
   localparam int TIMEOUT  = 16;
   localparam int MEM_SIZE = 1024;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          inst_req, data_req, data_write;
   logic [W-1:0]  inst_address, data_address, data_wdata;
   logic          inst_ack, inst_err, data_ack, data_err;
   logic [W-1:0]  inst_rdata, data_rdata;
   logic          mem_start, mem_write_enabled, mem_read_enabled;
   logic [W-1:0]  mem_address, mem_input_data;
   logic          mem_valid = 1'b0;
   logic [W-1:0]  mem_output_data = '0;
   logic          mem_err_invalid_address;
   logic          busy;

   int assert_count = 0;
   int fail_count   = 0;

   int read_delay = 0;
   bit no_valid   = 1'b0;
   bit last_was_data = 1'b0;

   logic [W-1:0] ref_mem [MEM_SIZE];

   memory_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .inst_req(inst_req), .inst_address(inst_address), .inst_ack(inst_ack),
      .inst_rdata(inst_rdata), .inst_err(inst_err),
      .data_req(data_req), .data_write(data_write), .data_address(data_address),
      .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata), .data_err(data_err),
      .mem_start(mem_start), .mem_write_enabled(mem_write_enabled), .mem_read_enabled(mem_read_enabled),
      .mem_address(mem_address), .mem_input_data(mem_input_data), .mem_valid(mem_valid),
      .mem_output_data(mem_output_data), .mem_err_invalid_address(mem_err_invalid_address),
      .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] init_word(input int i);
      if (i == 5) return 32'hDEAD_BEEF;
      return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0007);
   endfunction

   // Stub memory: acts on the rising edge of mem_start, returns read data after read_delay cycles.
   logic [W-1:0] stub_mem [MEM_SIZE];
   bit           written [MEM_SIZE];
   logic         start_q = 1'b0;
   int           start_count = 0;
   int           start_high  = 0;
   bit           last_we = 1'b0, last_re = 1'b0;
   bit           active = 1'b0;
   int           delay_cnt = 0;
   logic [9:0]   rd_idx = '0;

   assign mem_err_invalid_address = (mem_address >= 32'(MEM_SIZE));

   function automatic logic [W-1:0] stub_read(input logic [9:0] idx);
      return written[idx] ? stub_mem[idx] : init_word(int'(idx));
   endfunction

   always @(posedge clock) begin
      start_q   <= mem_start;
      mem_valid <= 1'b0;
      if (mem_start) start_high <= start_high + 1;
      if (!reset_n) begin
         active <= 1'b0;
      end else if (mem_start && !start_q) begin
         start_count <= start_count + 1;
         last_we     <= mem_write_enabled;
         last_re     <= mem_read_enabled;
         if (mem_write_enabled) begin
            stub_mem[mem_address[9:0]] <= mem_input_data;
            written[mem_address[9:0]]  <= 1'b1;
         end else if (!no_valid) begin
            if (read_delay == 0) begin
               mem_valid       <= 1'b1;
               mem_output_data <= stub_read(mem_address[9:0]);
            end else begin
               active    <= 1'b1;
               delay_cnt <= read_delay - 1;
               rd_idx    <= mem_address[9:0];
            end
         end
      end else if (active) begin
         if (delay_cnt == 0) begin
            mem_valid       <= 1'b1;
            mem_output_data <= stub_read(rd_idx);
            active          <= 1'b0;
         end else begin
            delay_cnt <= delay_cnt - 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One single-requester transaction; caller is at a negedge with the DUT idle.
   task automatic applyStimulus(input bit use_data, input bit wr, input logic [W-1:0] addr,
                                input logic [W-1:0] wdata, input int delay, input bit scramble);
      int           exp_lat, exp_starts, starts0, high0, k;
      bit           exp_err, got, other_seen, is_wr;
      logic [W-1:0] exp_rdata, obs_rdata;
      logic         obs_err;
      is_wr      = use_data && wr;
      read_delay = delay;
      exp_rdata  = '0;
      exp_err    = 1'b0;
      if (addr >= 32'(MEM_SIZE)) begin
         exp_lat = 2; exp_err = 1'b1; exp_starts = 0;
      end else if (is_wr) begin
         exp_lat = 4; exp_starts = 1;
      end else if (no_valid) begin
         exp_lat = 3 + TIMEOUT; exp_err = 1'b1; exp_starts = 1;
      end else begin
         exp_lat = 4 + delay; exp_starts = 1; exp_rdata = ref_mem[addr[9:0]];
      end
      last_was_data = use_data;
      starts0 = start_count;
      high0   = start_high;
      if (use_data) begin
         data_req = 1'b1; data_write = wr; data_address = addr; data_wdata = wdata;
      end else begin
         inst_req = 1'b1; inst_address = addr;
      end
      got = 1'b0; other_seen = 1'b0; k = 0;
      while (!got && k < 60) begin
         @(posedge clock); @(negedge clock); k++;
         if (scramble && k == 2) begin
            inst_address = $urandom; data_address = $urandom;
            data_wdata = $urandom; data_write = 1'($urandom);
         end
         if (use_data ? data_ack : inst_ack) got = 1'b1;
         if (use_data ? inst_ack : data_ack) other_seen = 1'b1;
      end
      obs_err   = use_data ? data_err : inst_err;
      obs_rdata = use_data ? data_rdata : inst_rdata;
      inst_req = 1'b0; data_req = 1'b0;
      checkOutput("ack_latency", 32'(k), 32'(exp_lat));
      checkOutput("other_port_ack", 32'(other_seen), 32'd0);
      checkOutput("err", 32'(obs_err), 32'(exp_err));
      checkOutput("rdata", obs_rdata, exp_rdata);
      checkOutput("start_pulses", 32'(start_count - starts0), 32'(exp_starts));
      checkOutput("start_high_cycles", 32'(start_high - high0), 32'(exp_starts));
      if (exp_starts == 1) begin
         checkOutput("enables_at_start", {30'd0, last_we, last_re}, {30'd0, is_wr, !is_wr});
      end
      if (is_wr && !exp_err) ref_mem[addr[9:0]] = wdata;
      @(posedge clock); @(negedge clock);
      checkOutput("idle_after_resp", {29'd0, busy, inst_ack, data_ack}, 32'd0);
   endtask

   // Both ports held; grants must follow the tie-break rule for n consecutive transactions.
   task automatic arbitrate(input int n);
      bit exp_data;
      int k;
      read_delay = 0;
      inst_req = 1'b1; inst_address = 32'd10;
      data_req = 1'b1; data_address = 32'd20; data_write = 1'b0; data_wdata = '0;
      for (int t = 0; t < n; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_data = !last_was_data;
`else
         exp_data = 1'b1;
`endif
         k = 0;
         do begin
            @(posedge clock); @(negedge clock); k++;
         end while (!inst_ack && !data_ack && k < 20);
         checkOutput("arb_both_acks", 32'(inst_ack && data_ack), 32'd0);
         checkOutput("arb_grant", 32'(data_ack), 32'(exp_data));
         checkOutput("arb_rdata", exp_data ? data_rdata : inst_rdata,
                     exp_data ? ref_mem[20] : ref_mem[10]);
         last_was_data = exp_data;
      end
      inst_req = 1'b0; data_req = 1'b0;
      @(posedge clock); @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W-1:0] a;
      int ka;
      for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_word(i);
      reset_n = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_write = 1'b0;
      inst_address = '0; data_address = '0; data_wdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_flags", {24'd0, inst_ack, inst_err, data_ack, data_err,
                  mem_start, mem_write_enabled, mem_read_enabled, busy}, 32'd0);
      checkOutput("reset_inst_rdata", inst_rdata, 32'd0);
      checkOutput("reset_data_rdata", data_rdata, 32'd0);
      checkOutput("reset_mem_address", mem_address, 32'd0);
      checkOutput("reset_mem_wdata", mem_input_data, 32'd0);
      reset_n = 1'b1;
      last_was_data = 1'b0;
      @(negedge clock);

      $display("[TB] directed: fetch, store/load, bad address, timeout");
      applyStimulus(1'b0, 1'b0, 32'd5, 32'd0, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'd7, 32'h1234, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd7, 32'd0, 2, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'd0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd1023, 32'd0, 3, 1'b0);
      no_valid = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd9, 32'd0, 0, 1'b0);
      no_valid = 1'b0;

      $display("[TB] arbitration with both ports held");
      arbitrate(4);

      $display("[TB] reset during WAIT");
      no_valid = 1'b1;
      inst_req = 1'b1; inst_address = 32'd3;
      repeat (3) begin @(posedge clock); @(negedge clock); end
      checkOutput("busy_in_wait", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(posedge clock); @(negedge clock);
      checkOutput("abort_flags", {29'd0, busy, mem_start, inst_ack}, 32'd0);
      inst_req = 1'b0;
      @(posedge clock); @(negedge clock);
      reset_n = 1'b1; no_valid = 1'b0; last_was_data = 1'b0;
      ka = 0;
      repeat (4) begin @(posedge clock); @(negedge clock); if (inst_ack || data_ack) ka++; end
      checkOutput("no_ack_after_abort", 32'(ka), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'd3, 32'd0, 1, 1'b0);

      $display("[TB] randomized single-port traffic");
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) == 0) a = 32'(1024 + $urandom_range(0, 100));
         else a = 32'($urandom_range(0, 31));
         applyStimulus(1'($urandom), 1'($urandom), a, $urandom,
                       int'($urandom_range(0, 3)), 1'($urandom));
      end
      arbitrate(3);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
